coherence_bus_arbiter: RTL

COHERENCE_BUS_ARBITER -- requirements
Module: coherence_bus_arbiter

---
 rtl/coherence_bus_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/coherence_bus_arbiter.sv
// Two-CPU snooping coherence bus arbiter: serialises read-miss, write-miss and
// invalidate requests onto one broadcast bus with round-robin tie breaking.
module coherence_bus_arbiter #(
    parameter int SNOOP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu0_read_miss,
    input  logic        cpu0_write_miss,
    input  logic        cpu0_invalidate,
    input  logic [10:0] cpu0_bico,
    input  logic        cpu0_search_found,
    output logic        cpu0_search,
    output logic        cpu0_grant,
    output logic [1:0]  cpu0_datasel,
    output logic        cpu0_inv_from_other,
    input  logic        cpu1_read_miss,
    input  logic        cpu1_write_miss,
    input  logic        cpu1_invalidate,
    input  logic [10:0] cpu1_bico,
    input  logic        cpu1_search_found,
    output logic        cpu1_search,
    output logic        cpu1_grant,
    output logic [1:0]  cpu1_datasel,
    output logic        cpu1_inv_from_other,
    output logic [12:0] boci,
    output logic        mem_re,
    output logic [10:0] mem_addr,
    input  logic        mem_rdy,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SNOOP = 3'd1;
    localparam logic [2:0] S_MEM   = 3'd2;
    localparam logic [2:0] S_INV   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [1:0] OP_IDLE  = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_INV   = 2'b11;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_MEM  = 2'b01;
    localparam logic [1:0] SRC_CPU  = 2'b10;

    localparam logic [3:0] SNOOP_LAST = 4'(SNOOP_CYCLES - 1);

    logic [2:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  datasel_q, datasel_d;
    logic [10:0] addr_q, addr_d;
    logic [3:0]  snoop_cnt_q, snoop_cnt_d;

    logic [1:0]  cpu0_op, cpu1_op;
    logic        cpu0_req, cpu1_req;
    logic        winner;
    logic        other_found;

    // Within one CPU a write miss outranks a read miss, which outranks an invalidate.
    always_comb begin
        cpu0_op = OP_IDLE;
        if (cpu0_write_miss)      cpu0_op = OP_WRITE;
        else if (cpu0_read_miss)  cpu0_op = OP_READ;
        else if (cpu0_invalidate) cpu0_op = OP_INV;
        cpu1_op = OP_IDLE;
        if (cpu1_write_miss)      cpu1_op = OP_WRITE;
        else if (cpu1_read_miss)  cpu1_op = OP_READ;
        else if (cpu1_invalidate) cpu1_op = OP_INV;
    end

    assign cpu0_req    = (cpu0_op != OP_IDLE);
    assign cpu1_req    = (cpu1_op != OP_IDLE);
    assign other_found = owner_q ? cpu0_search_found : cpu1_search_found;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        op_d         = op_q;
        addr_d       = addr_q;
        datasel_d    = datasel_q;
        snoop_cnt_d  = snoop_cnt_q;
        last_grant_d = last_grant_q;
        winner       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cpu0_req || cpu1_req) begin
                    winner      = (cpu0_req && cpu1_req) ? ~last_grant_q : cpu1_req;
                    owner_d     = winner;
                    op_d        = winner ? cpu1_op : cpu0_op;
                    addr_d      = winner ? cpu1_bico : cpu0_bico;
                    datasel_d   = SRC_NONE;
                    snoop_cnt_d = 4'd0;
                    state_d     = (op_d == OP_INV) ? S_INV : S_SNOOP;
                end
            end
            S_SNOOP: begin
                if (snoop_cnt_q == SNOOP_LAST) begin
                    if (other_found) begin
                        datasel_d = SRC_CPU;
                        state_d   = (op_q == OP_READ) ? S_DONE : S_INV;
                    end else begin
                        state_d = S_MEM;
                    end
                end else begin
                    snoop_cnt_d = snoop_cnt_q + 4'd1;
                end
            end
            S_MEM: begin
                if (mem_rdy) begin
                    datasel_d = SRC_MEM;
                    state_d   = (op_q == OP_READ) ? S_DONE : S_INV;
                end
            end
            S_INV: state_d = S_DONE;
            S_DONE: begin
                last_grant_d = owner_q;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // last_grant resets to CPU1 so that CPU0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            op_q         <= OP_IDLE;
            datasel_q    <= SRC_NONE;
            addr_q       <= 11'd0;
            snoop_cnt_q  <= 4'd0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            op_q         <= op_d;
            datasel_q    <= datasel_d;
            addr_q       <= addr_d;
            snoop_cnt_q  <= snoop_cnt_d;
        end
    end

    // Outputs decode purely from state, so reset clears them without waiting for a clock.
    always_comb begin
        cpu0_search         = 1'b0;
        cpu1_search         = 1'b0;
        cpu0_grant          = 1'b0;
        cpu1_grant          = 1'b0;
        cpu0_datasel        = SRC_NONE;
        cpu1_datasel        = SRC_NONE;
        cpu0_inv_from_other = 1'b0;
        cpu1_inv_from_other = 1'b0;
        boci                = 13'd0;
        mem_re              = 1'b0;
        mem_addr            = 11'd0;
        case (state_q)
            S_SNOOP: begin
                boci = {op_q, addr_q};
                if (owner_q) cpu0_search = 1'b1;
                else         cpu1_search = 1'b1;
            end
            S_MEM: begin
                mem_re   = 1'b1;
                mem_addr = addr_q;
            end
            S_INV: begin
                boci = {OP_INV, addr_q};
                if (owner_q) cpu0_inv_from_other = 1'b1;
                else         cpu1_inv_from_other = 1'b1;
            end
            S_DONE: begin
                if (owner_q) begin
                    cpu1_grant   = 1'b1;
                    cpu1_datasel = datasel_q;
                end else begin
                    cpu0_grant   = 1'b1;
                    cpu0_datasel = datasel_q;
                end
            end
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);

endmodule
